// File: rtl/tilemap_vram_arbiter_pkg.sv
// rtl/tilemap_vram_arbiter_pkg.sv - shared geometry constants and FSM encoding for the tile-map VRAM arbiter
// Purpose: one place for the 640x480 / 16x16-tile geometry and the arbiter state encoding.
// Ports: none (package).
package tilemap_vram_arbiter_pkg;

  localparam int H_VISIBLE  = 640;
  localparam int V_VISIBLE  = 480;
  localparam int V_TOTAL    = 525;
  localparam int TILE_SHIFT = 4;
  localparam int COLS       = H_VISIBLE >> TILE_SHIFT;
  localparam int ROWS       = V_VISIBLE >> TILE_SHIFT;
  localparam int TILE_BITS  = 8;
  localparam int ADDR_BITS  = 11;

  localparam int COL_BITS = $clog2(COLS);      // line-buffer write index
  localparam int IDX_BITS = 11 - TILE_SHIFT;   // h_cnt >> TILE_SHIFT
  localparam int ROW_BITS = 10 - TILE_SHIFT;   // next_line >> TILE_SHIFT

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CPU_ACC = 3'd1,
    ST_CPU_RD  = 3'd2,
    ST_FETCH   = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

endpackage

// File: rtl/tilemap_vram_arbiter_tile_line_buffer.sv
// rtl/tilemap_vram_arbiter_tile_line_buffer.sv - one tile row of codes, 1 write port, 1 registered read port
// Purpose: holds the COLS tile codes of the row being displayed.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset (clears all entries and the read register)
//   i_we          write enable
//   i_waddr       write column (0..COLS-1)
//   i_wdata       tile code to store
//   i_raddr       read column (h_cnt >> TILE_SHIFT, may exceed COLS-1 during blanking)
//   o_rdata       registered read data, 0 for out-of-range columns
module tile_line_buffer
  import tilemap_vram_arbiter_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_we,
  input  logic [COL_BITS-1:0]  i_waddr,
  input  logic [TILE_BITS-1:0] i_wdata,
  input  logic [IDX_BITS-1:0]  i_raddr,
  output logic [TILE_BITS-1:0] o_rdata
);

  logic [TILE_BITS-1:0] r_mem [COLS];
  logic [TILE_BITS-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < COLS; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      // Columns past the visible width occur in hblank; return 0 rather than alias.
      r_rdata <= (i_raddr < IDX_BITS'(COLS)) ? r_mem[i_raddr[COL_BITS-1:0]] : '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tilemap_vram_arbiter.sv
// rtl/tilemap_vram_arbiter.sv - shares the single-port tile-map RAM between CPU and VGA tile-row bursts
// Purpose: bursts one tile row into a line buffer during hblank, serves CPU accesses otherwise,
//          forwards frame-end as an interrupt.
// Ports:
//   i_clk, i_rst           pixel clock, synchronous active-high reset
//   i_h_cnt, i_v_cnt       VGA timing counters
//   i_frame_end            1-cycle pulse on last pixel of frame
//   i_cpu_req/we/addr/wdata CPU request, held until o_cpu_ack
//   o_cpu_ack, o_cpu_rdata ack pulse; read data (valid with ack, then held)
//   o_frame_irq            i_frame_end delayed one cycle
//   o_ram_*/i_ram_rdata    single-port RAM, 1-cycle read latency
//   o_tile_code            line_buf[h_cnt >> TILE_SHIFT], registered
module tilemap_vram_arbiter
  import tilemap_vram_arbiter_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [10:0]          i_h_cnt,
  input  logic [9:0]           i_v_cnt,
  input  logic                 i_frame_end,
  input  logic                 i_cpu_req,
  input  logic                 i_cpu_we,
  input  logic [ADDR_BITS-1:0] i_cpu_addr,
  input  logic [TILE_BITS-1:0] i_cpu_wdata,
  output logic                 o_cpu_ack,
  output logic [TILE_BITS-1:0] o_cpu_rdata,
  output logic                 o_frame_irq,
  output logic                 o_ram_en,
  output logic                 o_ram_we,
  output logic [ADDR_BITS-1:0] o_ram_addr,
  output logic [TILE_BITS-1:0] o_ram_wdata,
  input  logic [TILE_BITS-1:0] i_ram_rdata,
  output logic [TILE_BITS-1:0] o_tile_code
);

  state_t               r_state, w_next_state;
  logic [9:0]           w_next_line;
  logic [ROW_BITS-1:0]  w_burst_row;
  logic                 w_fetch_trig;
  logic                 r_pending;
  logic [ADDR_BITS-1:0] r_base;
  logic [COL_BITS-1:0]  r_col;
  logic [COL_BITS-1:0]  r_wr_col;
  logic                 r_wr_en;
  logic [TILE_BITS-1:0] r_cpu_rdata;
  logic                 r_frame_irq;

  assign w_next_line  = (i_v_cnt == 10'(V_TOTAL - 1)) ? '0 : i_v_cnt + 10'd1;
  assign w_burst_row  = w_next_line[9:TILE_SHIFT];
  assign w_fetch_trig = (i_h_cnt == 11'(H_VISIBLE)) &&
                        (w_next_line < 10'(V_VISIBLE)) &&
                        (w_next_line[TILE_SHIFT-1:0] == '0);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic: a tile-row burst always wins over the CPU in IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fetch_trig || r_pending) w_next_state = ST_FETCH;
        else if (i_cpu_req)            w_next_state = ST_CPU_ACC;
      end
      ST_CPU_ACC: w_next_state = i_cpu_we ? ST_IDLE : ST_CPU_RD;
      ST_CPU_RD:  w_next_state = ST_IDLE;
      ST_FETCH:   if (r_col == COL_BITS'(COLS - 1)) w_next_state = ST_DRAIN;
      ST_DRAIN:   w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    o_ram_en    = 1'b0;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    o_cpu_ack   = 1'b0;
    o_cpu_rdata = r_cpu_rdata;
    case (r_state)
      ST_CPU_ACC: begin
        o_ram_en    = 1'b1;
        o_ram_we    = i_cpu_we;
        o_ram_addr  = i_cpu_addr;
        o_ram_wdata = i_cpu_wdata;
        o_cpu_ack   = i_cpu_we;
      end
      ST_CPU_RD: begin
        // Read data is presented combinationally so it is valid in the ack cycle.
        o_cpu_ack   = 1'b1;
        o_cpu_rdata = i_ram_rdata;
      end
      ST_FETCH: begin
        o_ram_en   = 1'b1;
        o_ram_addr = r_base + ADDR_BITS'(r_col);
      end
      default: ;
    endcase
  end

  // Burst counters, pending trigger, CPU read hold and irq
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pending   <= 1'b0;
      r_base      <= '0;
      r_col       <= '0;
      r_wr_col    <= '0;
      r_wr_en     <= 1'b0;
      r_cpu_rdata <= '0;
      r_frame_irq <= 1'b0;
    end else begin
      r_frame_irq <= i_frame_end;
      if (r_state == ST_CPU_RD) r_cpu_rdata <= i_ram_rdata;
      // A trigger seen while the CPU owns the RAM is held until IDLE consumes it.
      r_pending <= (r_state == ST_IDLE) ? 1'b0 : (r_pending | w_fetch_trig);
      // Row base advances one row per trigger; row 0 resynchronises it each frame.
      if (w_fetch_trig) r_base <= (w_burst_row == '0) ? '0 : r_base + ADDR_BITS'(COLS);
      r_col <= (r_state == ST_FETCH) ? r_col + 1'b1 : '0;
      // RAM data returns one cycle after the address, so the write column trails by one.
      r_wr_en  <= (r_state == ST_FETCH);
      r_wr_col <= r_col;
    end
  end

  assign o_frame_irq = r_frame_irq;

  tile_line_buffer u_line_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (r_wr_en),
    .i_waddr (r_wr_col),
    .i_wdata (i_ram_rdata),
    .i_raddr (i_h_cnt[10:TILE_SHIFT]),
    .o_rdata (o_tile_code)
  );

endmodule

// File: tb/tb_tilemap_vram_arbiter.sv
// tb/tb_tilemap_vram_arbiter.sv - directed self-checking bench for tilemap_vram_arbiter
module tb_tilemap_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_end;
  logic        cpu_req, cpu_we;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        frame_irq;
  logic        ram_en, ram_we;
  logic [10:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  tile_code;

  logic [7:0]  mem [2048];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          rd_addr [$];
  int          rd_stamp [$];

  tilemap_vram_arbiter dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_h_cnt     (h_cnt),
    .i_v_cnt     (v_cnt),
    .i_frame_end (frame_end),
    .i_cpu_req   (cpu_req),
    .i_cpu_we    (cpu_we),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wdata (cpu_wdata),
    .o_cpu_ack   (cpu_ack),
    .o_cpu_rdata (cpu_rdata),
    .o_frame_irq (frame_irq),
    .o_ram_en    (ram_en),
    .o_ram_we    (ram_we),
    .o_ram_addr  (ram_addr),
    .o_ram_wdata (ram_wdata),
    .i_ram_rdata (ram_rdata),
    .o_tile_code (tile_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // Log every RAM read with the cycle it was issued in
  always @(negedge clk) begin
    if (ram_en === 1'b1 && ram_we === 1'b0) begin
      rd_addr.push_back(int'(ram_addr));
      rd_stamp.push_back(cyc);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_addr.delete();
    rd_stamp.delete();
  endtask

  task automatic burst_check(input string tag, input int base, input int ref_cyc,
                             input int dmin, input int dmax);
    int nbad;
    int d;
    nbad = 0;
    check_val({tag, "_count"}, rd_addr.size(), 40);
    if (rd_addr.size() >= 40) begin
      for (int k = 0; k < 40; k++) if (rd_addr[k] != base + k) nbad++;
      check_val({tag, "_addr_errs"}, nbad, 0);
      check_val({tag, "_span"}, rd_stamp[39] - rd_stamp[0], 39);
      d = rd_stamp[0] - ref_cyc;
      check_val({tag, "_start_ok"}, (d >= dmin && d <= dmax), 1);
    end
  endtask

  task automatic cpu_access(input logic we, input logic [10:0] addr, input logic [7:0] wdata,
                            output int lat, output logic we_seen, output logic [10:0] addr_seen,
                            output logic [7:0] wdata_seen, output logic [7:0] rdata_seen);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = -1; we_seen = 1'b0; addr_seen = '0; wdata_seen = '0; rdata_seen = '0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (cpu_ack === 1'b1) begin
        lat = i; we_seen = ram_we; addr_seen = ram_addr;
        wdata_seen = ram_wdata; rdata_seen = cpu_rdata;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  int          lat, t0, ack_cyc, we_bad, en_cnt;
  logic        we_s;
  logic [10:0] addr_s;
  logic [7:0]  wd_s, rd_s;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'(8'hC0 + i);
    for (int k = 0; k < 40; k++) mem[40 + k] = 8'(k + 1);
    rst = 1'b1; h_cnt = '0; v_cnt = '0; frame_end = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_val("rst_ram_en", ram_en, 0);
    check_val("rst_cpu_ack", cpu_ack, 0);
    check_val("rst_tile_code", tile_code, 0);
    check_val("rst_frame_irq", frame_irq, 0);
    check_val("rst_cpu_rdata", cpu_rdata, 0);

    // 1. last visible line: no burst; end of frame: burst of row 0
    clear_log();
    v_cnt = 10'd479; h_cnt = 11'd640;
    tick(); h_cnt = 11'd641;
    repeat (4) tick();
    check_val("t1_no_burst_479", rd_addr.size(), 0);
    clear_log();
    v_cnt = 10'd524; h_cnt = 11'd640; t0 = cyc;
    tick(); h_cnt = 11'd641;
    repeat (45) tick();
    burst_check("t1_row0", 0, t0, 1, 1);

    // 2. row 1 burst, then renderer lookups
    clear_log();
    v_cnt = 10'd15; h_cnt = 11'd640; t0 = cyc;
    tick(); h_cnt = 11'd641;
    repeat (45) tick();
    burst_check("t2_row1", 40, t0, 1, 1);
    v_cnt = 10'd16;
    h_cnt = 11'd32;  tick(); check_val("t2_tile_col2", tile_code, 3);
    h_cnt = 11'd639; tick(); check_val("t2_tile_col39", tile_code, 40);
    h_cnt = 11'd0;   tick(); check_val("t2_tile_col0", tile_code, 1);
    h_cnt = 11'd320; tick(); check_val("t2_tile_col20", tile_code, 21);
    h_cnt = 11'd700; tick();

    // 3. CPU write then readback
    cpu_access(1'b1, 11'd5, 8'hA5, lat, we_s, addr_s, wd_s, rd_s);
    check_val("t3_wr_lat", lat, 1);
    check_val("t3_wr_we", we_s, 1);
    check_val("t3_wr_addr", addr_s, 5);
    check_val("t3_wr_data", wd_s, 8'hA5);
    tick();
    check_val("t3_mem5", mem[5], 8'hA5);
    cpu_access(1'b0, 11'd5, 8'h00, lat, we_s, addr_s, wd_s, rd_s);
    check_val("t3_rd_lat", lat, 2);
    check_val("t3_rd_data", rd_s, 8'hA5);
    tick(); tick();
    check_val("t3_rd_hold", cpu_rdata, 8'hA5);

    // 4. read request one cycle ahead of the trigger
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'd5;
    tick();
    check_val("t4_no_early_ack", cpu_ack, 0);
    v_cnt = 10'd524; h_cnt = 11'd640;
    tick(); h_cnt = 11'd641;
    check_val("t4_ack", cpu_ack, 1);
    check_val("t4_rdata", cpu_rdata, 8'hA5);
    cpu_req = 1'b0; ack_cyc = cyc;
    clear_log();
    repeat (46) tick();
    burst_check("t4_burst", 0, ack_cyc, 1, 2);

    // 5. write request coincident with the trigger is stalled past the burst
    clear_log();
    v_cnt = 10'd524; h_cnt = 11'd640; t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'd7; cpu_wdata = 8'h3C;
    lat = -1; we_bad = 0;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 1) h_cnt = 11'd641;
      if (ram_we === 1'b1 && cpu_ack !== 1'b1) we_bad++;
      if (cpu_ack === 1'b1) begin
        lat = i;
        break;
      end
    end
    cpu_req = 1'b0;
    check_val("t5_ack_lat_ok", (lat >= 42 && lat <= 43), 1);
    check_val("t5_we_in_burst", we_bad, 0);
    tick(); tick();
    burst_check("t5_burst", 0, t0, 1, 1);
    check_val("t5_mem7", mem[7], 8'h3C);

    // 6. reset mid-burst, then frame interrupt
    clear_log();
    v_cnt = 10'd524; h_cnt = 11'd640;
    tick(); h_cnt = 11'd641;
    for (int i = 0; i < 60; i++) begin
      if (rd_addr.size() >= 21) break;
      tick();
    end
    check_val("t6_reached_col20", rd_addr.size(), 21);
    rst = 1'b1;
    tick();
    check_val("t6_en_in_rst", ram_en, 0);
    rst = 1'b0;
    en_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (ram_en === 1'b1 || cpu_ack === 1'b1) en_cnt++;
    end
    check_val("t6_idle_after_rst", en_cnt, 0);
    check_val("t6_reads_total", rd_addr.size(), 22);
    h_cnt = 11'd32; tick();
    check_val("t6_buf_cleared", tile_code, 0);
    cpu_access(1'b1, 11'd9, 8'h55, lat, we_s, addr_s, wd_s, rd_s);
    check_val("t6_wr_lat_idle", lat, 1);
    tick();
    check_val("t6_irq_before", frame_irq, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    check_val("t6_irq_pulse", frame_irq, 1);
    tick();
    check_val("t6_irq_width", frame_irq, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
